// File: rtl/blaster_top.sv
// Capacitor-discharge igniter controller: ADC frame capture, charge/fire/dump sequencing and firing-current regulation.
// Defining BLASTER_OCP_EN adds an over-current FAULT state that latches until reset.
`timescale 1ns/1ps
module blaster_top #(
    parameter int FIRE_CYCLES    = 48000,
    parameter int TONE_DIV       = 12000,
    parameter int DUMP_DONE_CODE = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm_button,
    input  logic       fire_button,
    input  logic       cont,
    input  logic       lt3420_done,
    output logic       lt3420_charge,
    input  logic [2:0] iset,
    output logic       pwm,
    output logic       dump,
    output logic       arm_led,
    output logic       cont_led,
    output logic       speaker,
    output logic       ad_cs,
    input  logic [1:0] ad_sdata_a,
    input  logic [1:0] ad_sdata_b
);

    localparam int FIRE_W = $clog2(FIRE_CYCLES + 1);
    localparam int TONE_W = $clog2(TONE_DIV + 1);
    localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(FIRE_CYCLES - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [11:0] DUMP_CODE = 12'(DUMP_DONE_CODE);

    // Frame counter value of the last frame slot; cs is high in slots 0 and 1.
    localparam logic [3:0] SLOT_LAST      = 4'd15;
    localparam logic [3:0] SLOT_FIRST_BIT = 4'd3;
    localparam logic [3:0] SLOT_LAST_BIT  = 4'd14;

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        READY,
        FIRE,
        DISCHARGE,
        FAULT
    } state_t;

    logic [1:0] arm_sync;
    logic [1:0] fire_sync;
    logic [1:0] cont_sync;
    logic [1:0] done_sync;
    logic       arm_s;
    logic       fire_s;
    logic       cont_s;
    logic       done_s;

    logic [3:0]       frame_cnt;
    logic [3:0]       lane;
    logic [3:0][11:0] shift_reg;
    logic [11:0]      vout_code;
    logic [11:0]      iout_code;
    logic [11:0]      vcap_code;
    logic [11:0]      icap_code;
    logic             new_sample;
    logic             sample_unused;

    state_t            state;
    state_t            state_nxt;
    logic [FIRE_W-1:0] fire_cnt;
    logic [TONE_W-1:0] tone_cnt;
    logic [11:0]       iset_code;
    logic              fire_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_sync  <= '0;
            fire_sync <= '0;
            cont_sync <= '0;
            done_sync <= '0;
        end else begin
            arm_sync  <= {arm_sync[0], arm_button};
            fire_sync <= {fire_sync[0], fire_button};
            cont_sync <= {cont_sync[0], cont};
            done_sync <= {done_sync[0], lt3420_done};
        end
    end

    assign arm_s    = arm_sync[1];
    assign fire_s   = fire_sync[1];
    assign cont_s   = cont_sync[1];
    assign done_s   = done_sync[1];
    assign cont_led = cont_s;

    // Lane order: [3]=vout, [2]=iout, [1]=vcap, [0]=icap.
    assign lane = {ad_sdata_a, ad_sdata_b};

    // Reset parks the counter on the last slot so the first frame after release starts with two cs-high cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt  <= SLOT_LAST;
            ad_cs      <= 1'b1;
            shift_reg  <= '0;
            vout_code  <= '0;
            iout_code  <= '0;
            vcap_code  <= '0;
            icap_code  <= '0;
            new_sample <= 1'b0;
        end else begin
            frame_cnt  <= frame_cnt + 4'd1;
            ad_cs      <= (frame_cnt == SLOT_LAST) || (frame_cnt == 4'd0);
            new_sample <= 1'b0;
            if (frame_cnt >= SLOT_FIRST_BIT && frame_cnt <= SLOT_LAST_BIT) begin
                for (int i = 0; i < 4; i++) begin
                    shift_reg[i] <= {shift_reg[i][10:0], lane[i]};
                end
            end
            if (frame_cnt == SLOT_LAST_BIT) begin
                vout_code  <= {shift_reg[3][10:0], lane[3]};
                iout_code  <= {shift_reg[2][10:0], lane[2]};
                vcap_code  <= {shift_reg[1][10:0], lane[1]};
                icap_code  <= {shift_reg[0][10:0], lane[0]};
                new_sample <= 1'b1;
            end
        end
    end

    assign sample_unused = ^{vout_code, icap_code, shift_reg};

    assign iset_code = {1'b0, iset, 8'd0};
    assign fire_done = (fire_cnt == FIRE_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (arm_s) state_nxt = CHARGE;
            CHARGE:    if (!arm_s) state_nxt = DISCHARGE;
                       else if (done_s) state_nxt = READY;
            READY:     if (!arm_s) state_nxt = DISCHARGE;
                       else if (fire_s && cont_s) state_nxt = FIRE;
            FIRE:      if (!arm_s || fire_done) state_nxt = DISCHARGE;
            DISCHARGE: if ((vcap_code < DUMP_CODE) && !fire_s) state_nxt = IDLE;
`ifdef BLASTER_OCP_EN
            FAULT:     state_nxt = FAULT;
`endif
            default:   state_nxt = IDLE;
        endcase
`ifdef BLASTER_OCP_EN
        if (new_sample && (iout_code[11] || icap_code[11])) state_nxt = FAULT;
`endif
    end

    // Outputs are registered from the next state so pwm falls on the same edge that leaves FIRE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            fire_cnt      <= '0;
            tone_cnt      <= '0;
            pwm           <= 1'b0;
            dump          <= 1'b0;
            lt3420_charge <= 1'b0;
            arm_led       <= 1'b0;
            speaker       <= 1'b0;
        end else begin
            state         <= state_nxt;
            lt3420_charge <= (state_nxt == CHARGE) || (state_nxt == READY);
            dump          <= (state_nxt == DISCHARGE) || (state_nxt == FAULT);
            arm_led       <= (state_nxt == READY) || (state_nxt == FIRE);

            if (state == FIRE && state_nxt == FIRE) fire_cnt <= fire_cnt + FIRE_W'(1);
            else fire_cnt <= '0;

            if (state_nxt != FIRE) pwm <= 1'b0;
            else if (new_sample) pwm <= (iout_code < iset_code);

            if (state_nxt == READY || state_nxt == FIRE) begin
                if (tone_cnt == TONE_LAST) begin
                    tone_cnt <= '0;
                    speaker  <= ~speaker;
                end else begin
                    tone_cnt <= tone_cnt + TONE_W'(1);
                end
            end else begin
                tone_cnt <= '0;
                speaker  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blaster_top.sv
// Scoreboard bench for blaster_top: lane driver queues expected ADC words, a monitor compares them on each new sample.
`timescale 1ns/1ps
module tb_blaster_top;

    localparam int FIRE_CYCLES    = 600;
    localparam int TONE_DIV       = 20;
    localparam int DUMP_DONE_CODE = 80;

    typedef struct packed {
        logic [11:0] vout;
        logic [11:0] iout;
        logic [11:0] vcap;
        logic [11:0] icap;
    } sample_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arm_button = 1'b0;
    logic       fire_button = 1'b0;
    logic       cont = 1'b0;
    logic       lt3420_done = 1'b0;
    logic [2:0] iset = 3'd0;
    logic [1:0] ad_sdata_a = 2'b00;
    logic [1:0] ad_sdata_b = 2'b00;
    logic       lt3420_charge;
    logic       pwm;
    logic       dump;
    logic       arm_led;
    logic       cont_led;
    logic       speaker;
    logic       ad_cs;

    logic [11:0] vout_w = 12'h0A0;
    logic [11:0] iout_w = 12'h200;
    logic [11:0] vcap_w = 12'hA00;
    logic [11:0] icap_w = 12'h055;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sample_count = 0;
    int fire_entry = 0;
    sample_t sb[$];

    blaster_top #(
        .FIRE_CYCLES(FIRE_CYCLES),
        .TONE_DIV(TONE_DIV),
        .DUMP_DONE_CODE(DUMP_DONE_CODE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .arm_button(arm_button),
        .fire_button(fire_button),
        .cont(cont),
        .lt3420_done(lt3420_done),
        .lt3420_charge(lt3420_charge),
        .iset(iset),
        .pwm(pwm),
        .dump(dump),
        .arm_led(arm_led),
        .cont_led(cont_led),
        .speaker(speaker),
        .ad_cs(ad_cs),
        .ad_sdata_a(ad_sdata_a),
        .ad_sdata_b(ad_sdata_b)
    );

    always #10 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic arm, input logic fire, input logic c, input logic done, input logic [2:0] is);
        @(negedge clk);
        arm_button  = arm;
        fire_button = fire;
        cont        = c;
        lt3420_done = done;
        iset        = is;
    endtask

    task automatic doReset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #2;
        sb.delete();
    endtask

    task automatic releaseReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitSamples(input int n);
        int start;
        int budget;
        start  = sample_count;
        budget = 20 * n + 20;
        while (sample_count < start + n && budget > 0) begin
            nextCycle();
            budget--;
        end
        if (sample_count < start + n) failNow("wait_samples");
    endtask

    task automatic waitFire(input string name, input int bound);
        int waited;
        waited = 0;
        while (!(lt3420_charge == 1'b0 && arm_led == 1'b1) && waited < bound) begin
            nextCycle();
            waited++;
        end
        checkOutput(name, 32'(!lt3420_charge && arm_led), 32'd1);
        fire_entry = cyc;
    endtask

    task automatic measureTone(input string name);
        logic prev;
        int n;
        nextCycle();
        prev = speaker;
        n = 0;
        do begin nextCycle(); n++; end while (speaker == prev && n < 3 * TONE_DIV);
        prev = speaker;
        n = 0;
        do begin nextCycle(); n++; end while (speaker == prev && n < 3 * TONE_DIV);
        checkOutput(name, 32'(n), 32'(TONE_DIV));
    endtask

    task automatic pwmStep(input string name, input logic [2:0] is, input logic [11:0] word, input logic expected);
        @(negedge clk);
        iset   = is;
        iout_w = word;
        waitSamples(2);
        nextCycle();
        checkOutput(name, 32'(pwm), 32'(expected));
    endtask

    // Drives the four lanes MSB-first on falling edges, latching each frame's words when cs drops.
    initial begin : lane_driver
        int j;
        sample_t cur;
        j = -1;
        cur = '0;
        forever begin
            @(negedge clk);
            if (reset || ad_cs !== 1'b0) j = -1;
            else j = j + 1;
            if (j == 0) cur = {vout_w, iout_w, vcap_w, icap_w};
            if (j >= 1 && j <= 12) begin
                ad_sdata_a = {cur.vout[12-j], cur.iout[12-j]};
                ad_sdata_b = {cur.vcap[12-j], cur.icap[12-j]};
            end else begin
                ad_sdata_a = 2'b00;
                ad_sdata_b = 2'b00;
            end
            if (j == 12 && !reset) sb.push_back(cur);
        end
    end

    initial begin : monitor
        sample_t exp;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && dut.new_sample === 1'b1) begin
                sample_count++;
                if (sb.size() == 0) begin
                    failNow("sb_empty");
                end else begin
                    exp = sb.pop_front();
                    checkOutput("vout_code", 32'(dut.vout_code), 32'(exp.vout));
                    checkOutput("iout_code", 32'(dut.iout_code), 32'(exp.iout));
                    checkOutput("vcap_code", 32'(dut.vcap_code), 32'(exp.vcap));
                    checkOutput("icap_code", 32'(dut.icap_code), 32'(exp.icap));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: bench did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_pwm", 32'(pwm), 32'd0);
        checkOutput("rst_dump", 32'(dump), 32'd0);
        checkOutput("rst_charge", 32'(lt3420_charge), 32'd0);
        checkOutput("rst_arm_led", 32'(arm_led), 32'd0);
        checkOutput("rst_cont_led", 32'(cont_led), 32'd0);
        checkOutput("rst_speaker", 32'(speaker), 32'd0);
        checkOutput("rst_ad_cs", 32'(ad_cs), 32'd1);
        sb.delete();
        releaseReset();

        for (int i = 0; i < 32; i++) begin
            nextCycle();
            checkOutput($sformatf("ad_cs_c%0d", i), 32'(ad_cs), 32'((i % 16) < 2));
        end

        // Arm and charge into READY, then fire.
        iout_w = 12'd0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd2);
        repeat (10) nextCycle();
        checkOutput("ready_charge", 32'(lt3420_charge), 32'd1);
        checkOutput("ready_arm_led", 32'(arm_led), 32'd1);
        checkOutput("ready_cont_led", 32'(cont_led), 32'd1);
        checkOutput("ready_pwm", 32'(pwm), 32'd0);
        checkOutput("ready_dump", 32'(dump), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
        waitFire("fire_entry", 4);
        waitSamples(2);
        nextCycle();
        checkOutput("pwm_iout0", 32'(pwm), 32'd1);
        checkOutput("fire_charge", 32'(lt3420_charge), 32'd0);
        measureTone("tone_fire");

        pwmStep("pwm_511", 3'd2, 12'd511, 1'b1);
        pwmStep("pwm_512", 3'd2, 12'd512, 1'b0);
        pwmStep("pwm_511b", 3'd2, 12'd511, 1'b1);
        pwmStep("pwm_iset0", 3'd0, 12'd0, 1'b0);
        pwmStep("pwm_1791", 3'd7, 12'd1791, 1'b1);
        pwmStep("pwm_1792", 3'd7, 12'd1792, 1'b0);
        pwmStep("pwm_restore", 3'd2, 12'd0, 1'b1);
        checkOutput("fire_arm_led", 32'(arm_led), 32'd1);

        begin
            int waited;
            waited = 0;
            while (dump !== 1'b1 && waited < FIRE_CYCLES + 40) begin
                nextCycle();
                waited++;
            end
        end
        checkOutput("fire_duration", 32'(cyc - fire_entry), 32'(FIRE_CYCLES));
        checkOutput("timeout_pwm", 32'(pwm), 32'd0);
        checkOutput("timeout_dump", 32'(dump), 32'd1);
        checkOutput("timeout_arm_led", 32'(arm_led), 32'd0);
        checkOutput("timeout_speaker", 32'(speaker), 32'd0);

        // Discharge threshold boundary.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd2);
        waitSamples(2);
        nextCycle();
        checkOutput("dump_vcap_high", 32'(dump), 32'd1);
        vcap_w = 12'd80;
        waitSamples(2);
        nextCycle();
        checkOutput("dump_vcap80", 32'(dump), 32'd1);
        vcap_w = 12'd79;
        waitSamples(2);
        nextCycle();
        checkOutput("dump_vcap79", 32'(dump), 32'd0);
        checkOutput("idle_charge", 32'(lt3420_charge), 32'd0);

        // Disarm while charging.
        vcap_w = 12'hA00;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
        waitSamples(2);
        nextCycle();
        checkOutput("charge_state", 32'(lt3420_charge), 32'd1);
        checkOutput("charge_arm_led", 32'(arm_led), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
        repeat (4) nextCycle();
        checkOutput("disarm_dump", 32'(dump), 32'd1);
        checkOutput("disarm_charge", 32'(lt3420_charge), 32'd0);
        vcap_w = 12'd0;
        waitSamples(2);
        nextCycle();
        checkOutput("disarm_idle", 32'(dump), 32'd0);

        // No continuity holds READY even with fire pressed.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
        repeat (12) nextCycle();
        checkOutput("nocont_charge", 32'(lt3420_charge), 32'd1);
        checkOutput("nocont_arm_led", 32'(arm_led), 32'd1);
        checkOutput("nocont_cont_led", 32'(cont_led), 32'd0);
        measureTone("tone_ready");
        checkOutput("nocont_still_ready", 32'(lt3420_charge), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
        waitFire("fire_entry_cont", 4);
        waitSamples(2);
        nextCycle();
        checkOutput("pwm_before_reset", 32'(pwm), 32'd1);

        doReset(1);
        checkOutput("midfire_reset_pwm", 32'(pwm), 32'd0);
        checkOutput("midfire_reset_arm_led", 32'(arm_led), 32'd0);
        checkOutput("midfire_reset_ad_cs", 32'(ad_cs), 32'd1);
        repeat (2) nextCycle();
        releaseReset();

        waitFire("fire_reentry", 10);
        waitSamples(2);
        nextCycle();
        checkOutput("pwm_reentry", 32'(pwm), 32'd1);
        iout_w = 12'd2048;
        waitSamples(2);
        nextCycle();
`ifdef BLASTER_OCP_EN
        checkOutput("ocp_pwm", 32'(pwm), 32'd0);
        checkOutput("ocp_dump", 32'(dump), 32'd1);
        checkOutput("ocp_arm_led", 32'(arm_led), 32'd0);
`else
        checkOutput("high_iout_pwm", 32'(pwm), 32'd0);
        checkOutput("high_iout_dump", 32'(dump), 32'd0);
        checkOutput("high_iout_arm_led", 32'(arm_led), 32'd1);
`endif
        iout_w = 12'd0;
        vcap_w = 12'd0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd2);
        waitSamples(2);
        nextCycle();
`ifdef BLASTER_OCP_EN
        checkOutput("fault_latched_dump", 32'(dump), 32'd1);
        checkOutput("fault_latched_pwm", 32'(pwm), 32'd0);
`else
        checkOutput("back_idle_dump", 32'(dump), 32'd0);
        checkOutput("back_idle_pwm", 32'(pwm), 32'd0);
`endif

        doReset(3);
        checkOutput("final_pwm", 32'(pwm), 32'd0);
        checkOutput("final_dump", 32'(dump), 32'd0);
        checkOutput("final_charge", 32'(lt3420_charge), 32'd0);
        checkOutput("final_arm_led", 32'(arm_led), 32'd0);
        checkOutput("final_speaker", 32'(speaker), 32'd0);
        checkOutput("final_ad_cs", 32'(ad_cs), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
